// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: instruction word layout,
// field offsets/widths and the sequencer state encoding.
package calc_pkg;

  localparam int unsigned INSTR_W  = 23;
  localparam int unsigned CTRL_W   = 4;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned IMM_W    = 8;

  localparam int unsigned RPT_POS  = 22;
  localparam int unsigned CTRL_LSB = 18;
  localparam int unsigned SEL_POS  = 17;
  localparam int unsigned RW_LSB   = 14;
  localparam int unsigned RX_LSB   = 11;
  localparam int unsigned RY_LSB   = 8;
  localparam int unsigned IMM_LSB  = 0;

  // Member order matches the bit layout of In_instr, MSB first.
  typedef struct packed {
    logic              rpt;
    logic [CTRL_W-1:0] ctrl;
    logic              sel;
    logic [REG_W-1:0]  rw;
    logic [REG_W-1:0]  rx;
    logic [REG_W-1:0]  ry;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_READ = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/calc_instr_fifo.sv
// Instruction queue for the sequencer. DEPTH entries, count-based full/empty,
// pointers wrap modulo DEPTH. DEPTH=1 degenerates to a single holding register.
// Ports: Clk/Rst_n (sync active-low), push/push_data, pop, head (combinational
// view of the oldest entry), full, empty. Push is ignored when full, pop when empty.
module calc_instr_fifo
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   Clk,
  input  logic   Rst_n,
  input  logic   push,
  input  instr_t push_data,
  input  logic   pop,
  output instr_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  instr_t           mem_q [DEPTH];
  instr_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count makes its contents unobservable.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator instruction sequencer. Queues 23-bit instruction words, issues
// each as a one-cycle WEN pulse on the calculator control outputs and, for
// Rpt=1 instructions, reads the result back (busY, Carry) and presents it on a
// valid/ready result port.
// Ports: Clk, Rst_n (sync active-low); In_valid/In_ready/In_instr instruction
// input; WEN, RW, RX, RY, DataIn, Sel, Ctrl calculator controls (registered);
// busY, Carry calculator feedback; Res_valid/Res_data/Res_carry/Res_ready result.
// Build option: CALC_SEQ_FIFO_EN defined -> FIFO_DEPTH-entry queue; undefined ->
// single-entry holding register, accepting input only while IDLE.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [INSTR_W-1:0] In_instr,
  output logic               WEN,
  output logic [REG_W-1:0]   RW,
  output logic [REG_W-1:0]   RX,
  output logic [REG_W-1:0]   RY,
  output logic [DATA_W-1:0]  DataIn,
  output logic               Sel,
  output logic [CTRL_W-1:0]  Ctrl,
  input  logic [DATA_W-1:0]  busY,
  input  logic               Carry,
  output logic               Res_valid,
  output logic [DATA_W-1:0]  Res_data,
  output logic               Res_carry,
  input  logic               Res_ready
);

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("calc_sequencer: FIFO_DEPTH must be a power of two in 2..16");
  end

`ifdef CALC_SEQ_FIFO_EN
  localparam int unsigned Q_DEPTH = FIFO_DEPTH;
`else
  localparam int unsigned Q_DEPTH = 1;
`endif

  state_e             state_q, state_d;
  instr_t             issue_q, issue_d;
  logic               carry_q, carry_d;
  logic [DATA_W-1:0]  res_data_q, res_data_d;
  logic               res_carry_q, res_carry_d;
  logic               res_valid_q, res_valid_d;
  logic               wen_q, wen_d;
  logic [REG_W-1:0]   rw_q, rw_d, rx_q, rx_d, ry_q, ry_d;
  logic [DATA_W-1:0]  data_in_q, data_in_d;
  logic               sel_q, sel_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;

  logic   fifo_full, fifo_empty, push, pop;
  instr_t fifo_head;

`ifdef CALC_SEQ_FIFO_EN
  assign In_ready = Rst_n && !fifo_full;
`else
  assign In_ready = Rst_n && !fifo_full && (state_q == ST_IDLE);
`endif
  assign push = In_valid && In_ready;

  calc_instr_fifo #(
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (push),
    .push_data (instr_t'(In_instr)),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next state, issue/result capture, and registered calculator outputs
  // derived from the next state so they line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    carry_d     = carry_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    pop         = 1'b0;
    wen_d       = 1'b0;
    rw_d        = '0;
    rx_d        = '0;
    ry_d        = '0;
    data_in_d   = '0;
    sel_d       = 1'b0;
    ctrl_d      = '0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          issue_d = fifo_head;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        carry_d = Carry;
        if (issue_q.rpt) begin
          state_d = ST_READ;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          issue_d = fifo_head;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        res_data_d  = busY;
        res_carry_d = carry_q;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        // Res_valid is high throughout HOLD, so Res_ready alone completes it.
        if (Res_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            issue_d = fifo_head;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_EXEC) begin
      wen_d     = 1'b1;
      rw_d      = issue_d.rw;
      rx_d      = issue_d.rx;
      ry_d      = issue_d.ry;
      data_in_d = DATA_W'(issue_d.imm);
      sel_d     = issue_d.sel;
      ctrl_d    = issue_d.ctrl;
    end else if (state_d == ST_READ) begin
      // Point the calculator's read port at the register just written.
      ry_d = issue_d.rw;
    end
    res_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      issue_q     <= '0;
      carry_q     <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      rw_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      data_in_q   <= '0;
      sel_q       <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      carry_q     <= carry_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_valid_q <= res_valid_d;
      wen_q       <= wen_d;
      rw_q        <= rw_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      data_in_q   <= data_in_d;
      sel_q       <= sel_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign WEN       = wen_q;
  assign RW        = rw_q;
  assign RX        = rx_q;
  assign RY        = ry_q;
  assign DataIn    = data_in_q;
  assign Sel       = sel_q;
  assign Ctrl      = ctrl_q;
  assign Res_valid = res_valid_q;
  assign Res_data  = res_data_q;
  assign Res_carry = res_carry_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: inputs driven 1 time unit after the rising
// edge, outputs sampled on the falling edge. Covers both build variants of the
// instruction queue (CALC_SEQ_FIFO_EN defined or not).
module tb_calc_sequencer;

`ifdef CALC_SEQ_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        Clk;
  logic        Rst_n;
  logic        In_valid;
  logic        In_ready;
  logic [22:0] In_instr;
  logic        WEN;
  logic [2:0]  RW, RX, RY;
  logic [7:0]  DataIn;
  logic        Sel;
  logic [3:0]  Ctrl;
  logic [7:0]  busY;
  logic        Carry;
  logic        Res_valid;
  logic [7:0]  Res_data;
  logic        Res_carry;
  logic        Res_ready;

  int n_checks = 0;
  int n_errors = 0;

  calc_sequencer #(
    .FIFO_DEPTH (4),
    .DATA_W     (8)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_instr  (In_instr),
    .WEN       (WEN),
    .RW        (RW),
    .RX        (RX),
    .RY        (RY),
    .DataIn    (DataIn),
    .Sel       (Sel),
    .Ctrl      (Ctrl),
    .busY      (busY),
    .Carry     (Carry),
    .Res_valid (Res_valid),
    .Res_data  (Res_data),
    .Res_carry (Res_carry),
    .Res_ready (Res_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] mk(input logic rpt, input logic [3:0] ctrl, input logic sel,
                                     input logic [2:0] rw, input logic [2:0] rx,
                                     input logic [2:0] ry, input logic [7:0] imm);
    return {rpt, ctrl, sel, rw, rx, ry, imm};
  endfunction

  task automatic next_cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  // Push an Rpt=1 word and advance to the READ cycle (3 cycles after the push cycle).
  task automatic to_read(input logic [22:0] w);
    next_cyc(); In_valid = 1'b1; In_instr = w; smp();
    next_cyc(); In_valid = 1'b0; smp();
    next_cyc(); smp();
    next_cyc(); smp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; In_valid = 1'b0; In_instr = '0; busY = '0; Carry = 1'b0; Res_ready = 1'b0;

    // Reset state
    next_cyc(); next_cyc(); smp();
    check_eq("rst_wen",       WEN,       0);
    check_eq("rst_rw",        RW,        0);
    check_eq("rst_datain",    DataIn,    0);
    check_eq("rst_ctrl",      Ctrl,      0);
    check_eq("rst_res_valid", Res_valid, 0);
    check_eq("rst_res_data",  Res_data,  0);
    check_eq("rst_res_carry", Res_carry, 0);
    check_eq("rst_in_ready",  In_ready,  0);
    next_cyc(); Rst_n = 1'b1; smp();
    check_eq("rel_in_ready",  In_ready,  1);
    check_eq("rel_wen",       WEN,       0);

    // Single Rpt=0 instruction: WEN two cycles after the push cycle.
    next_cyc(); In_valid = 1'b1; In_instr = mk(1'b0, 4'h2, 1'b0, 3'd3, 3'd1, 3'd2, 8'h35); smp();
    check_eq("s_rdy_c0", In_ready, 1);
    check_eq("s_wen_c0", WEN, 0);
    next_cyc(); In_valid = 1'b0; smp();
    check_eq("s_wen_c1", WEN, 0);
    check_eq("s_rdy_c1", In_ready, FIFO_EN);
    next_cyc(); smp();
    check_eq("s_wen_c2",  WEN,    1);
    check_eq("s_rw_c2",   RW,     3);
    check_eq("s_rx_c2",   RX,     1);
    check_eq("s_ry_c2",   RY,     2);
    check_eq("s_data_c2", DataIn, 8'h35);
    check_eq("s_ctrl_c2", Ctrl,   4'h2);
    check_eq("s_sel_c2",  Sel,    0);
    check_eq("s_rdy_c2",  In_ready, FIFO_EN);
    next_cyc(); smp();
    check_eq("s_wen_c3",  WEN,    0);
    check_eq("s_rw_c3",   RW,     0);
    check_eq("s_data_c3", DataIn, 0);
    check_eq("s_ctrl_c3", Ctrl,   0);
    check_eq("s_rdy_c3",  In_ready, 1);

    // Rpt=1 readback: Carry only in EXEC, busY only in READ, then held result.
    next_cyc(); In_valid = 1'b1; In_instr = mk(1'b1, 4'h5, 1'b1, 3'd5, 3'd2, 3'd3, 8'h10); smp();
    next_cyc(); In_valid = 1'b0; smp();
    check_eq("r_wen_c1", WEN, 0);
    next_cyc(); Carry = 1'b1; smp();
    check_eq("r_wen_exec",  WEN,    1);
    check_eq("r_rw_exec",   RW,     5);
    check_eq("r_sel_exec",  Sel,    1);
    check_eq("r_ctrl_exec", Ctrl,   4'h5);
    check_eq("r_data_exec", DataIn, 8'h10);
    next_cyc(); Carry = 1'b0; busY = 8'hA7; smp();
    check_eq("r_wen_read",  WEN,       0);
    check_eq("r_ry_read",   RY,        5);
    check_eq("r_rw_read",   RW,        0);
    check_eq("r_vld_read",  Res_valid, 0);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); busY = 8'h00; Res_ready = 1'b0; smp();
      check_eq($sformatf("r_hold_vld%0d", i),   Res_valid, 1);
      check_eq($sformatf("r_hold_data%0d", i),  Res_data,  8'hA7);
      check_eq($sformatf("r_hold_carry%0d", i), Res_carry, 1);
      check_eq($sformatf("r_hold_wen%0d", i),   WEN,       0);
    end
    next_cyc(); Res_ready = 1'b1; smp();
    check_eq("r_hs_vld", Res_valid, 1);
    next_cyc(); Res_ready = 1'b0; smp();
    check_eq("r_post_vld", Res_valid, 0);
    check_eq("r_post_wen", WEN,       0);
    check_eq("r_post_rdy", In_ready,  1);

`ifdef CALC_SEQ_FIFO_EN
    // Four back-to-back pushes give four consecutive WEN cycles.
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      if (i < 4) begin
        In_valid = 1'b1;
        In_instr = mk(1'b0, 4'h1, 1'b0, 3'(i), 3'd0, 3'd0, 8'(8'h40 + i));
      end else begin
        In_valid = 1'b0;
      end
      smp();
      if (i < 4) check_eq($sformatf("b_rdy%0d", i), In_ready, 1);
      if (i >= 2) begin
        check_eq($sformatf("b_wen%0d", i),  WEN,    1);
        check_eq($sformatf("b_rw%0d", i),   RW,     i - 2);
        check_eq($sformatf("b_data%0d", i), DataIn, 8'h40 + i - 2);
      end
    end
    next_cyc(); smp();
    check_eq("b_wen_end", WEN, 0);

    // Fill the queue while a result is held; the 5th waits for the handshake pop.
    to_read(mk(1'b1, 4'h3, 1'b0, 3'd7, 3'd0, 3'd0, 8'h00));
    for (int i = 0; i < 4; i++) begin
      next_cyc(); In_valid = 1'b1; In_instr = mk(1'b0, 4'h0, 1'b0, 3'(i), 3'd0, 3'd0, 8'(i)); smp();
      check_eq($sformatf("f_rdy%0d", i), In_ready,  1);
      check_eq($sformatf("f_vld%0d", i), Res_valid, 1);
    end
    for (int i = 0; i < 2; i++) begin
      next_cyc(); In_instr = mk(1'b0, 4'h0, 1'b0, 3'd4, 3'd0, 3'd0, 8'd4); smp();
      check_eq($sformatf("f_full_rdy%0d", i), In_ready, 0);
      check_eq($sformatf("f_full_wen%0d", i), WEN,      0);
    end
    next_cyc(); Res_ready = 1'b1; smp();
    check_eq("f_hs_rdy", In_ready,  0);
    check_eq("f_hs_vld", Res_valid, 1);
    for (int i = 0; i < 6; i++) begin
      next_cyc(); Res_ready = 1'b0; In_valid = (i == 0); smp();
      if (i == 0) check_eq("f_fifth_rdy", In_ready, 1);
      if (i < 5) begin
        check_eq($sformatf("f_wen%0d", i), WEN, 1);
        check_eq($sformatf("f_rw%0d", i),  RW,  i);
      end else begin
        check_eq("f_wen_end", WEN, 0);
      end
    end
`else
    // Single-entry queue: a second word stalls until the sequencer is IDLE again.
    next_cyc(); In_valid = 1'b1; In_instr = mk(1'b0, 4'h0, 1'b0, 3'd6, 3'd0, 3'd0, 8'h66); smp();
    check_eq("n_rdy_c0", In_ready, 1);
    next_cyc(); In_instr = mk(1'b0, 4'h0, 1'b0, 3'd7, 3'd0, 3'd0, 8'h77); smp();
    check_eq("n_rdy_c1", In_ready, 0);
    check_eq("n_wen_c1", WEN,      0);
    next_cyc(); smp();
    check_eq("n_rdy_c2", In_ready, 0);
    check_eq("n_wen_c2", WEN,      1);
    check_eq("n_rw_c2",  RW,       6);
    next_cyc(); smp();
    check_eq("n_rdy_c3", In_ready, 1);
    check_eq("n_wen_c3", WEN,      0);
    next_cyc(); In_valid = 1'b0; smp();
    check_eq("n_rdy_c4", In_ready, 0);
    check_eq("n_wen_c4", WEN,      0);
    next_cyc(); smp();
    check_eq("n_wen_c5",  WEN,    1);
    check_eq("n_rw_c5",   RW,     7);
    check_eq("n_data_c5", DataIn, 8'h77);
    next_cyc(); smp();
    check_eq("n_wen_c6", WEN,      0);
    check_eq("n_rdy_c6", In_ready, 1);
`endif

    // Reset while holding a result with queued words: everything is discarded.
    to_read(mk(1'b1, 4'h6, 1'b0, 3'd2, 3'd0, 3'd0, 8'h22));
    next_cyc(); In_valid = 1'b1; In_instr = mk(1'b0, 4'h0, 1'b0, 3'd1, 3'd0, 3'd0, 8'h01); smp();
    check_eq("x_vld_hold", Res_valid, 1);
    check_eq("x_rdy_q1",   In_ready,  FIFO_EN);
    next_cyc(); In_instr = mk(1'b0, 4'h0, 1'b0, 3'd2, 3'd0, 3'd0, 8'h02); smp();
    check_eq("x_rdy_q2",   In_ready,  FIFO_EN);
    next_cyc(); In_valid = 1'b0; Rst_n = 1'b0; smp();
    check_eq("x_rdy_rst",  In_ready,  0);
    next_cyc(); Rst_n = 1'b1; smp();
    check_eq("x_vld_rel",  Res_valid, 0);
    check_eq("x_data_rel", Res_data,  0);
    check_eq("x_wen_rel",  WEN,       0);
    check_eq("x_rdy_rel",  In_ready,  1);
    for (int i = 0; i < 5; i++) begin
      next_cyc(); smp();
      check_eq($sformatf("x_wen_after%0d", i), WEN,       0);
      check_eq($sformatf("x_vld_after%0d", i), Res_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
